// File: rtl/cv_ram_pkg.sv
// Shared constants and helpers for the byte-enabled true dual-port RAM and its port front ends.
package cv_ram_pkg;

    localparam int WORD_W        = 32;
    localparam int BE_W          = 4;
    localparam int A_WIDTH_DEF   = 10;
    localparam int RSP_DEPTH_DEF = 2;

    // Pointer width for a power-of-two queue depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic req_is_write(input logic [BE_W-1:0] we);
        return |we;
    endfunction

endpackage

// File: rtl/cv_sync_fifo.sv
// Single-clock circular-buffer FIFO with wrapping pointers and an occupancy count.
module cv_sync_fifo
    import cv_ram_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = RSP_DEPTH_DEF,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;

    assign full = (count == CNT_W'(DEPTH));

    // The head is masked while empty so the output reads zero out of reset.
    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop)) else $error("cv_sync_fifo overflow");
            assert (!(pop && (count == '0))) else $error("cv_sync_fifo underflow");
        end
    end

endmodule

// File: rtl/cv_tdpram_port_ctrl.sv
// Request/response front end for one port of the byte-enabled true dual-port RAM:
// posted writes, credit-limited reads, in-order read responses through a small FIFO.
module cv_tdpram_port_ctrl
    import cv_ram_pkg::*;
#(
    parameter int A_WIDTH   = A_WIDTH_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    // Handshakes: a beat transfers on a rising edge where valid and ready are both
    // high; a request is not taken back until accepted, and ready may depend on valid.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [BE_W-1:0]    req_we,
    input  logic [WORD_W-1:0]  req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WORD_W-1:0]  rsp_rdata,
    output logic               ram_en,
    output logic [BE_W-1:0]    ram_we,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [WORD_W-1:0]  ram_wrdata,
    input  logic [WORD_W-1:0]  ram_rddata,
    output logic               busy
);

    localparam int CNT_W = cnt_w(RSP_DEPTH);

    logic             is_wr;
    logic             acc;
    logic             rd_acc;
    logic             rsp_fire;
    logic             inflight;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] fifo_count;

    assign is_wr    = req_is_write(req_we);
    assign rsp_fire = rsp_valid & rsp_ready;

    // A response leaving this cycle frees a credit for a read arriving in the same
    // cycle, which is what keeps one read per cycle flowing at the minimum depth.
    assign req_ready = is_wr | (pend < CNT_W'(RSP_DEPTH)) | rsp_fire;

    assign acc    = req_valid & req_ready;
    assign rd_acc = acc & ~is_wr;

    assign ram_en     = acc;
    assign ram_we     = acc ? req_we    : '0;
    assign ram_addr   = acc ? req_addr  : '0;
    assign ram_wrdata = acc ? req_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            pend     <= '0;
        end else begin
            inflight <= rd_acc;
            case ({rd_acc, rsp_fire})
                2'b10:   pend <= pend + CNT_W'(1);
                2'b01:   pend <= pend - CNT_W'(1);
                default: pend <= pend;
            endcase
        end
    end

    // The RAM registers read data on the accept edge; it is captured one edge later.
    cv_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (ram_rddata),
        .pop       (rsp_fire),
        .pop_data  (rsp_rdata),
        .count     (fifo_count)
    );

    assign rsp_valid = (fifo_count != '0);
    assign busy      = inflight | rsp_valid;

endmodule

// File: tb/tb_cv_tdpram_port_ctrl.sv
// Self-checking bench for cv_tdpram_port_ctrl with a behavioural byte-enabled RAM port.
module tb_cv_tdpram_port_ctrl;
    import cv_ram_pkg::*;

    localparam int AW     = 10;
    localparam int DEPTH  = 2;
    localparam int N_RAND = 10000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic [3:0]      req_we;
    logic [31:0]     req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_rdata;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_wrdata;
    logic [31:0]     ram_rddata;
    logic            busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rsp    = 0;
    int          max_pend = 0;
    bit          last_acc;
    logic [31:0] exp_q[$];
    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    cv_tdpram_port_ctrl #(
        .A_WIDTH   (AW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wrdata (ram_wrdata),
        .ram_rddata (ram_rddata),
        .busy       (busy)
    );

    // RAM port model: registered read, old data on read, byte-enabled write.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) ram_rddata <= mem[ram_addr];
            else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_read(input logic [AW-1:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = 4'b0000;
        req_wdata = 32'h0;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = d;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 4'b0000;
        req_wdata = 32'h0;
    endtask

    // One clock: observe at the negedge, update the scoreboard, end #1 after posedge.
    task automatic step();
        logic [31:0] w;
        @(negedge clk);
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
        if (exp_q.size() > max_pend) max_pend = exp_q.size();
        if (req_valid) begin
            if (req_we != 4'b0000) check("wr_ready", 32'(req_ready), 32'd1);
            else check("rd_ready", 32'(req_ready),
                       32'((exp_q.size() < DEPTH) || (rsp_valid && rsp_ready)));
        end
        last_acc = req_valid && req_ready;
        check("ram_en", 32'(ram_en), 32'(last_acc));
        if (last_acc) begin
            check("ram_addr", 32'({ram_we, ram_addr}), 32'({req_we, req_addr}));
            check("ram_wrdata", ram_wrdata, req_wdata);
            if (req_we != 4'b0000) begin
                w = shadow[req_addr];
                for (int b = 0; b < 4; b++)
                    if (req_we[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
                shadow[req_addr] = w;
            end else begin
                exp_q.push_back(shadow[req_addr]);
            end
        end else begin
            check("ram_idle", 32'({ram_we, ram_addr}) | ram_wrdata, 32'd0);
        end
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
            else check("rsp_data", rsp_rdata, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            step();
            k++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int stalls;
        int acc_n;
        int a;
        int guard;
        int done;
        int cyc;
        bit have;
        logic [AW-1:0] r_addr;
        logic [3:0]    r_we;
        logic [31:0]   r_data;

        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'h5A000000 ^ (i * 32'h00010203);
            shadow[i] = mem[i];
        end
        mem[5]  = 32'hDEADBEEF; shadow[5]  = 32'hDEADBEEF;
        mem[16] = 32'hAAAAAAAA; shadow[16] = 32'hAAAAAAAA;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        rst_n = 1'b1;
        step();

        // Single read: latency and one-cycle RAM enable pulse.
        drive_read(10'h005);
        step();
        check("t1_acc", 32'(last_acc), 32'd1);
        idle();
        check("t1_lat_e0", 32'(rsp_valid), 32'd0);
        step();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_data", rsp_rdata, 32'hDEADBEEF);
        step();
        step();
        check("t1_busy_end", 32'(busy), 32'd0);

        // Byte-enabled posted write then read back.
        drive_write(10'h010, 4'b0101, 32'h11223344);
        step();
        check("t2_wr_acc", 32'(last_acc), 32'd1);
        idle();
        step();
        step();
        check("t2_no_rsp", 32'(rsp_valid), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);
        drive_read(10'h010);
        step();
        idle();
        step();
        check("t2_rsp_data", rsp_rdata, 32'hAA22AA44);
        step();
        step();

        // Back-to-back reads with the consumer always ready.
        rsp_ready = 1'b1;
        base = n_rsp; stalls = 0; a = 0; guard = 0;
        while (a < 256 && guard < 1000) begin
            drive_read(AW'(a));
            step();
            if (last_acc) a++;
            else stalls++;
            guard++;
        end
        idle();
        drain(20);
        check("t3_stalls", 32'(stalls), 32'd0);
        check("t3_count", 32'(n_rsp - base), 32'd256);

        // Backpressure: credits run out for reads, writes still pass.
        rsp_ready = 1'b0;
        acc_n = 0;
        for (int k = 0; k < 4; k++) begin
            drive_read(AW'(10'h040 + acc_n));
            step();
            if (last_acc) acc_n++;
        end
        check("t4_accepted", 32'(acc_n), 32'd2);
        drive_read(10'h050);
        #1;
        check("t4_rd_blocked", 32'(req_ready), 32'd0);
        drive_write(10'h020, 4'b1111, 32'hCAFEF00D);
        #1;
        check("t4_wr_ready", 32'(req_ready), 32'd1);
        step();
        check("t4_wr_acc", 32'(last_acc), 32'd1);
        idle();
        rsp_ready = 1'b1;
        base = n_rsp;
        drain(20);
        check("t4_drained", 32'(n_rsp - base), 32'd2);

        // Random valid/ready traffic against the scoreboard.
        done = 0; cyc = 0; have = 1'b0;
        r_addr = '0; r_we = '0; r_data = '0;
        while (done < N_RAND && cyc < 80000) begin
            if (!have) begin
                r_addr = AW'($urandom_range(0, 63));
                r_we   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                r_data = $urandom;
                have   = 1'b1;
            end
            req_addr  = r_addr;
            req_we    = r_we;
            req_wdata = r_data;
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
            if (last_acc) begin
                have = 1'b0;
                done++;
            end
            cyc++;
        end
        check("t5_done", 32'(done), 32'(N_RAND));
        idle();
        rsp_ready = 1'b1;
        drain(50);
        check("t5_pend_over", 32'(max_pend > DEPTH), 32'd0);

        // Reset with one response queued and one read in flight.
        rsp_ready = 1'b0;
        drive_read(10'h030);
        step();
        drive_read(10'h031);
        step();
        idle();
        check("t6_pre_valid", 32'(rsp_valid), 32'd1);
        check("t6_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_rdata", rsp_rdata, 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        step();
        check("t6_no_stale", 32'(rsp_valid), 32'd0);
        drive_read(10'h031);
        step();
        idle();
        step();
        check("t6_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t6_rsp_data", rsp_rdata, shadow[10'h031]);
        step();
        step();
        check("end_queue", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
